cdp_tx_dispatch: RTL and testbench
==================================

# cdp_tx_dispatch

Egress dispatcher on the CDP side of the user-module boundary, directly downstream of `um`. It accepts the forwarding rules (`um2cdp_rule`) and the packet word stream (`um2cdp_data`) that `um` produces, and buffers both. It pairs each packet with its rule in order and replicates the packet onto the output ports named in the rule's bitmap. It generates the `cdp2um_rule_usedw` and `cdp2um_tx_enable` backpressure that `um` obeys.

## Interface
Parameters:
- `NUM_PORTS`, 8: output ports; equals the bitmap width in the rule.
- `DATA_DEPTH`, 512: packet FIFO depth in 139-bit words; power of two.
- `MAX_PKT_WORDS`, 128: headroom required before `cdp2um_tx_enable` asserts.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `um2cdp_rule_wrreq` in 1: rule write strobe.
- `um2cdp_rule` in 30: rule fields:
  - [7:0] port bitmap;
  - [18:8] packet length in bytes;
  - [19] encap flag, ignored here;
  - [29:20] reserved.
- `cdp2um_rule_usedw` out 5: rule FIFO occupancy, 0..16.
- `um2cdp_data_valid` in 1: data word strobe.
- `um2cdp_data` in 139: packet word:
  - [138:136] tag: 101 head, 100 middle, 110 tail, 111 head+tail;
  - [135:132] valid bytes, 0 means 16;
  - [127:0] payload.
- `cdp2um_tx_enable` out 1: `um` may start a new packet.
- `port_data_valid` out NUM_PORTS: per-port word valid.
- `port_data` out 139: word shared by all ports.
- `port_ready` in NUM_PORTS: per-port accept.
- `len_err_cnt` out 16: saturating count of length mismatches.
- `ovf` out 1: sticky; set by a write into a full FIFO.

## Operation
Buffering:
- Rule FIFO: 16 entries, show-ahead.
  - A write while it holds 16 entries is discarded and sets `ovf`.
  - `cdp2um_rule_usedw` is registered and reflects writes and reads of the previous cycle.
- Data FIFO: DATA_DEPTH entries, show-ahead.
  - A write while full is discarded and sets `ovf`.
  - `cdp2um_tx_enable` = 1 when free entries ≥ MAX_PKT_WORDS. It is registered.

Dispatch FSM:
- IDLE
  - Rule FIFO not empty and data FIFO not empty → pop the rule; latch bitmap `bm` and length `len`; clear byte counter `bc`.
  - If `bm` = 0 → DROP, else → SEND.
- SEND
  - `port_data_valid` = `bm` and `port_data` = FIFO head.
  - A word is accepted when (`port_ready` & `bm`) == `bm`. On accept: pop the word and add its byte count to `bc` (16 for non-tail words, the [135:132] field for tail words).
  - While any selected port is not ready, the word is held and no port sees it advance (all-or-nothing replication).
  - Tail accepted → CHECK.
  - If the data FIFO is empty mid-packet, `port_data_valid` = 0 and the FSM waits in SEND.
- DROP
  - Pop one word per cycle while the FIFO is non-empty. No port valid; `bc` still counts.
  - Tail popped → CHECK.
- CHECK (one cycle)
  - If `bc` ≠ `len`, increment `len_err_cnt`; it saturates at FFFF.
  - → IDLE.
- A head tag seen in SEND or DROP after the first word is treated as the tail of the current packet; the mismatch is then flagged by CHECK.
- Reserved rule bits are ignored.

## Timing
- Reset values:
  - all `port_data_valid` 0, `port_data` 0;
  - `cdp2um_rule_usedw` 0, `cdp2um_tx_enable` 0 while reset is asserted and 1 on the first clock after release (FIFOs empty);
  - `len_err_cnt` 0, `ovf` 0;
  - FSM in IDLE; both FIFOs flushed.
- Reset mid-packet aborts immediately with no partial-packet completion.
- Latency from the first data word written into an empty block (rule already present):
  - word in FIFO at cycle n+1;
  - rule popped in IDLE at n+1;
  - `port_data_valid` at n+2.
- Throughput: one word per cycle when all selected ports are ready.
- Between packets: one CHECK cycle plus one IDLE cycle.
- Simultaneous write and read on a FIFO at full or empty:
  - at full, the write is discarded before the read is applied;
  - at empty, a read is not possible (no show-ahead data).
- Pointers wrap modulo depth. Usedw is one bit wider than the address.

## Structure
- Package `cdp_pkg` holds:
  - tag constants HEAD, MID, TAIL, HEADTAIL;
  - rule field offsets for BITMAP, LEN, ENCAP;
  - FSM state enum IDLE/SEND/DROP/CHECK.
- One sub-module, `sync_fifo` (parameters WIDTH, DEPTH; show-ahead; usedw/full/empty), instantiated twice: 30×16 and 139×DATA_DEPTH.

## Test plan
- Unicast: rule {len=64, bm=8'h04}, then 4 words (head, mid, mid, tail with vb=0) → port 2 sees 4 valid words in 4 consecutive cycles starting 2 cycles after the head write; other ports stay 0; `len_err_cnt` = 0.
- Multicast with backpressure: bm=8'h81, 3-word packet, `port_ready[7]` low for cycles 1–3 → no word advances on port 0 or port 7 until both are ready; each port receives exactly 3 words in order.
- Drop: bm=0, 5-word packet, followed by a unicast packet to port 1 → no output for the first packet; the second packet is delivered intact.
- Length error: rule len=60, 4 words with tail vb=0 (64 bytes) → `len_err_cnt` goes 0→1 in the CHECK cycle.
- Overflow: 17 rule writes with no data → `cdp2um_rule_usedw` = 16, `ovf` = 1; data fill to DATA_DEPTH−MAX_PKT_WORDS+1 words → `cdp2um_tx_enable` = 0.
- Reset mid-packet: assert `reset` during word 2 of 4 → all outputs 0 immediately, usedw 0; after release, a new packet is dispatched correctly.

Source files
------------

// File: rtl/cdp_pkg.sv
// cdp_pkg: tag codes, rule field offsets, dispatch states and byte-count helper
package cdp_pkg;
  localparam logic [2:0] HEAD = 3'b101, MID = 3'b100, TAIL = 3'b110, HEADTAIL = 3'b111;
  localparam int BITMAP = 0, LEN = 8, ENCAP = 19;
  localparam int RULE_W = 30, WORD_W = 139;
  typedef enum logic [1:0] {IDLE, SEND, DROP, CHECK} state_t;
  function automatic logic [4:0] word_bytes(input logic [3:0] vb);
    return vb == 4'd0 ? 5'd16 : {1'b0, vb};
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead FIFO with occupancy count; writes into a full FIFO are dropped
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wrreq,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     rdreq,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   usedw,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic wr_ok, rd_ok;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign usedw = cnt_q;
  assign rdata = mem[rp_q];
  always_comb begin
    wr_ok = wrreq && !full;
    rd_ok = rdreq && !empty;
    wp_d = wr_ok ? wp_q + AW'(1) : wp_q;
    rp_d = rd_ok ? rp_q + AW'(1) : rp_q;
    cnt_d = cnt_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
  end
  always_ff @(posedge clk)
    if (wr_ok) mem[wp_q] <= wdata;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/cdp_tx_dispatch.sv
// cdp_tx_dispatch: buffers rules and packet words from um, pairs them in order and
// replicates each packet all-or-nothing onto the ports selected by its bitmap
module cdp_tx_dispatch import cdp_pkg::*; #(
  parameter int NUM_PORTS = 8,
  parameter int DATA_DEPTH = 512,
  parameter int MAX_PKT_WORDS = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 um2cdp_rule_wrreq,
  input  logic [RULE_W-1:0]    um2cdp_rule,
  output logic [4:0]           cdp2um_rule_usedw,
  input  logic                 um2cdp_data_valid,
  input  logic [WORD_W-1:0]    um2cdp_data,
  output logic                 cdp2um_tx_enable,
  output logic [NUM_PORTS-1:0] port_data_valid,
  output logic [WORD_W-1:0]    port_data,
  input  logic [NUM_PORTS-1:0] port_ready,
  output logic [15:0]          len_err_cnt,
  output logic                 ovf
);
  localparam int DAW = $clog2(DATA_DEPTH);
  logic [RULE_W-1:0] rule_head;
  logic [WORD_W-1:0] data_head;
  logic [DAW:0] data_usedw;
  logic rule_rd, rule_full, rule_empty, data_rd, data_full, data_empty;
  state_t state_q, state_d;
  logic [NUM_PORTS-1:0] bm_q, bm_d;
  logic [10:0] len_q, len_d;
  logic [15:0] bc_q, bc_d, err_q, err_d;
  logic first_q, first_d, ovf_q, ovf_d, tx_en_q, tx_en_d;
  logic [2:0] tag;
  logic last, take, unused_rule;
  sync_fifo #(.WIDTH(RULE_W), .DEPTH(16)) u_rule_fifo (
    .clk(clk), .reset(reset), .wrreq(um2cdp_rule_wrreq), .wdata(um2cdp_rule),
    .rdreq(rule_rd), .rdata(rule_head), .usedw(cdp2um_rule_usedw),
    .full(rule_full), .empty(rule_empty)
  );
  sync_fifo #(.WIDTH(WORD_W), .DEPTH(DATA_DEPTH)) u_data_fifo (
    .clk(clk), .reset(reset), .wrreq(um2cdp_data_valid), .wdata(um2cdp_data),
    .rdreq(data_rd), .rdata(data_head), .usedw(data_usedw),
    .full(data_full), .empty(data_empty)
  );
  assign unused_rule = ^rule_head[RULE_W-1:ENCAP];
  // a head after the first word closes the packet; CHECK then reports the short length
  always_comb begin
    tag = data_head[WORD_W-1 -: 3];
    last = tag == TAIL || tag == HEADTAIL || (tag == HEAD && !first_q);
    take = !data_empty && (state_q == DROP || (state_q == SEND && (port_ready & bm_q) == bm_q));
    rule_rd = state_q == IDLE && !rule_empty && !data_empty;
    data_rd = take;
    state_d = state_q;
    bm_d = bm_q;
    len_d = len_q;
    first_d = first_q;
    err_d = err_q;
    bc_d = take ? bc_q + (last ? 16'(word_bytes(data_head[135:132])) : 16'd16) : bc_q;
    if (rule_rd) begin
      bm_d = rule_head[BITMAP +: NUM_PORTS];
      len_d = rule_head[LEN +: 11];
      bc_d = '0;
      first_d = 1'b1;
      state_d = bm_d == '0 ? DROP : SEND;
    end
    if (take) begin
      first_d = 1'b0;
      state_d = last ? CHECK : state_q;
    end
    if (state_q == CHECK) begin
      state_d = IDLE;
      err_d = (bc_q != {5'd0, len_q} && err_q != 16'hffff) ? err_q + 16'd1 : err_q;
    end
    ovf_d = ovf_q | (um2cdp_rule_wrreq & rule_full) | (um2cdp_data_valid & data_full);
    tx_en_d = data_usedw <= (DAW+1)'(DATA_DEPTH - MAX_PKT_WORDS);
    port_data_valid = (state_q == SEND && !data_empty) ? bm_q : '0;
    port_data = (state_q == SEND && !data_empty) ? data_head : '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      bm_q <= '0;
      len_q <= '0;
      bc_q <= '0;
      err_q <= '0;
      first_q <= 1'b0;
      ovf_q <= 1'b0;
      tx_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bm_q <= bm_d;
      len_q <= len_d;
      bc_q <= bc_d;
      err_q <= err_d;
      first_q <= first_d;
      ovf_q <= ovf_d;
      tx_en_q <= tx_en_d;
    end
  assign cdp2um_tx_enable = tx_en_q;
  assign len_err_cnt = err_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_cdp_tx_dispatch.sv
// tb_cdp_tx_dispatch: directed, table-driven and randomized checks of the egress dispatcher
// against per-port expected-word queues and a packet-level length-error model
module tb_cdp_tx_dispatch;
  import cdp_pkg::*;
  localparam int NP = 8, DD = 512, MPW = 128;
  logic clk = 1'b0, reset = 1'b1;
  logic rule_wr = 1'b0, dv = 1'b0, tx_en, ovf;
  logic [RULE_W-1:0] rule = '0;
  logic [WORD_W-1:0] din = '0, pdata, last_w, w0;
  logic [4:0] usedw;
  logic [NP-1:0] pvalid, pready = '1;
  logic [15:0] err;
  logic [7:0] cur_bm = '0;
  logic [WORD_W-1:0] expq [NP][$];
  int ncmp = 0, nfail = 0, exp_err = 0, seq = 0;
  bit rnd_rdy = 1'b0;
  typedef struct { logic [7:0] bm; int len; int n; logic [3:0] vb; int exp_err; } vec_t;
  vec_t vecs [8];
  always #5 clk = ~clk;
  cdp_tx_dispatch #(.NUM_PORTS(NP), .DATA_DEPTH(DD), .MAX_PKT_WORDS(MPW)) dut (
    .clk(clk), .reset(reset), .um2cdp_rule_wrreq(rule_wr), .um2cdp_rule(rule),
    .cdp2um_rule_usedw(usedw), .um2cdp_data_valid(dv), .um2cdp_data(din),
    .cdp2um_tx_enable(tx_en), .port_data_valid(pvalid), .port_data(pdata),
    .port_ready(pready), .len_err_cnt(err), .ovf(ovf)
  );
  task automatic chk(input string name, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask
  // a word moves only when every selected port is ready at the same edge
  task automatic monitor();
    if (!reset && pvalid != '0 && (pready & pvalid) == pvalid)
      for (int p = 0; p < NP; p++)
        if (pvalid[p]) begin
          if (expq[p].size() == 0) begin
            ncmp++;
            nfail++;
            $display("FAIL port%0d_extra: got %h, want no word", p, pdata);
          end else chk($sformatf("port%0d_word", p), pdata, expq[p].pop_front());
        end
  endtask
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (rnd_rdy) pready = ($urandom_range(0, 1) == 1) ? '1 : NP'($urandom);
  endtask
  function automatic bit q_empty();
    for (int p = 0; p < NP; p++) if (expq[p].size() != 0) return 1'b0;
    return 1'b1;
  endfunction
  function automatic logic [2:0] tag_of(input int i, input int n);
    return n == 1 ? HEADTAIL : i == 0 ? HEAD : i == n - 1 ? TAIL : MID;
  endfunction
  function automatic int pkt_bytes(input int n, input logic [3:0] vb);
    return 16 * (n - 1) + (vb == 4'd0 ? 16 : int'(vb));
  endfunction
  task automatic wr_word(input logic [2:0] tag, input logic [3:0] vb);
    seq++;
    last_w = {tag, vb, 4'(seq), $urandom, $urandom, $urandom, 32'(seq)};
    dv = 1'b1;
    din = last_w;
    for (int p = 0; p < NP; p++) if (cur_bm[p]) expq[p].push_back(last_w);
  endtask
  task automatic put_rule(input logic [7:0] bm, input int len);
    cur_bm = bm;
    rule_wr = 1'b1;
    rule = {10'($urandom), 1'($urandom), 11'(len), bm};
    step();
    rule_wr = 1'b0;
  endtask
  task automatic send_pkt(input logic [7:0] bm, input int len, input int n, input logic [3:0] vb, input bit gaps);
    int t = 0;
    while ((!tx_en || usedw >= 5'd14) && t < 2000) begin
      step();
      t++;
    end
    if (t >= 2000) begin
      ncmp++;
      nfail++;
      $display("FAIL send_wait: tx_enable %b usedw %0d, want room within 2000 cycles", tx_en, usedw);
    end
    put_rule(bm, len);
    for (int i = 0; i < n; i++) begin
      wr_word(tag_of(i, n), i == n - 1 ? vb : 4'($urandom));
      step();
      dv = 1'b0;
      if (gaps) repeat ($urandom_range(0, 2)) step();
    end
    if (pkt_bytes(n, vb) != len && exp_err < 65535) exp_err++;
  endtask
  task automatic drain(input int extra);
    int t = 0;
    while (!q_empty() && t < 5000) begin
      step();
      t++;
    end
    chk("drain_done", WORD_W'(t < 5000), WORD_W'(1));
    repeat (extra) step();
  endtask
  task automatic do_reset();
    reset = 1'b1;
    rule_wr = 1'b0;
    dv = 1'b0;
    rnd_rdy = 1'b0;
    pready = '1;
    step();
    step();
    chk("rst_valid", pvalid, 0);
    chk("rst_data", pdata, 0);
    chk("rst_usedw", usedw, 0);
    chk("rst_txen", tx_en, 0);
    chk("rst_err", err, 0);
    chk("rst_ovf", ovf, 0);
    reset = 1'b0;
    step();
    chk("txen_after_rst", tx_en, 1);
    for (int p = 0; p < NP; p++) expq[p].delete();
    exp_err = 0;
  endtask
  initial begin
    vecs = '{'{8'h02, 20, 2, 4'd4, 0}, '{8'hff, 16, 1, 4'd0, 0}, '{8'h00, 80, 5, 4'd0, 0},
             '{8'h02, 64, 4, 4'd0, 0}, '{8'h10, 60, 4, 4'd0, 1}, '{8'h00, 10, 3, 4'd3, 2},
             '{8'h40, 33, 3, 4'd1, 2}, '{8'h01, 100, 7, 4'd4, 2}};
    do_reset();
    // unicast: valid appears two cycles after the head write, four back-to-back words
    put_rule(8'h04, 64);
    wr_word(HEAD, 4'd0);
    step();
    chk("uni_n1", pvalid, 0);
    wr_word(MID, 4'd0);
    step();
    chk("uni_n2", pvalid, 8'h04);
    wr_word(MID, 4'd0);
    step();
    chk("uni_n3", pvalid, 8'h04);
    wr_word(TAIL, 4'd0);
    step();
    chk("uni_n4", pvalid, 8'h04);
    dv = 1'b0;
    step();
    chk("uni_n5", pvalid, 8'h04);
    step();
    chk("uni_check_gap", pvalid, 0);
    drain(4);
    chk("uni_err", err, 0);
    // multicast with port 7 stalled: the head word must stay put on both ports
    put_rule(8'h81, 48);
    pready = 8'h7f;
    wr_word(HEAD, 4'd0);
    w0 = last_w;
    step();
    wr_word(MID, 4'd0);
    step();
    wr_word(TAIL, 4'd0);
    step();
    dv = 1'b0;
    chk("hold_valid", pvalid, 8'h81);
    chk("hold_data1", pdata, w0);
    step();
    chk("hold_data2", pdata, w0);
    pready = '1;
    drain(4);
    chk("mc_err", err, 0);
    for (int i = 0; i < 8; i++) begin
      send_pkt(vecs[i].bm, vecs[i].len, vecs[i].n, vecs[i].vb, 1'b0);
      drain(20);
      chk($sformatf("tbl%0d_err", i), err, WORD_W'(vecs[i].exp_err));
    end
    // a second head closes the packet early and is counted as a length error
    put_rule(8'h02, 48);
    wr_word(HEAD, 4'd0);
    step();
    wr_word(MID, 4'd0);
    step();
    wr_word(HEAD, 4'd5);
    step();
    dv = 1'b0;
    drain(6);
    chk("head_as_tail_err", err, 3);
    send_pkt(8'h02, 32, 2, 4'd0, 1'b0);
    drain(10);
    chk("after_head_tail_err", err, 3);
    // reset in the middle of a packet
    put_rule(8'h08, 64);
    put_rule(8'h08, 64);
    wr_word(HEAD, 4'd0);
    step();
    wr_word(MID, 4'd0);
    step();
    chk("mid_valid", pvalid, 8'h08);
    chk("mid_usedw", usedw, 1);
    reset = 1'b1;
    dv = 1'b0;
    #1;
    chk("midrst_valid", pvalid, 0);
    chk("midrst_data", pdata, 0);
    chk("midrst_usedw", usedw, 0);
    chk("midrst_err", err, 0);
    for (int p = 0; p < NP; p++) expq[p].delete();
    step();
    reset = 1'b0;
    step();
    chk("midrst_txen", tx_en, 1);
    send_pkt(8'h08, 64, 4, 4'd0, 1'b0);
    drain(10);
    chk("midrst_recover_err", err, 0);
    // rule FIFO overflow
    do_reset();
    for (int i = 0; i < 17; i++) begin
      if (i == 16) chk("ovf_before", ovf, 0);
      rule_wr = 1'b1;
      rule = 30'($urandom);
      step();
    end
    rule_wr = 1'b0;
    step();
    chk("ovf_usedw", usedw, 16);
    chk("ovf_set", ovf, 1);
    // data fill up to the tx_enable threshold
    do_reset();
    dv = 1'b1;
    for (int i = 0; i < DD - MPW; i++) begin
      din = WORD_W'(i);
      step();
    end
    dv = 1'b0;
    step();
    step();
    chk("txen_at_threshold", tx_en, 1);
    dv = 1'b1;
    step();
    dv = 1'b0;
    step();
    step();
    chk("txen_below_threshold", tx_en, 0);
    chk("fill_no_ovf", ovf, 0);
    // randomized packets with random backpressure
    do_reset();
    rnd_rdy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      logic [7:0] bm;
      logic [3:0] vb;
      int n, len;
      bm = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      n = $urandom_range(1, 6);
      vb = 4'($urandom);
      len = ($urandom_range(0, 1) == 1) ? pkt_bytes(n, vb) : $urandom_range(1, 120);
      send_pkt(bm, len, n, vb, 1'b1);
    end
    drain(200);
    rnd_rdy = 1'b0;
    pready = '1;
    chk("rand_err", err, WORD_W'(exp_err));
    chk("rand_ovf", ovf, 0);
    chk("rand_usedw", usedw, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
